// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline: operand forwarding, load-use,
// data-memory wait and branch hazards, plus a scoreboard for multi-cycle mul/div results.
module hazard_ctrl #(
   parameter int REG_AW   = 5,
   parameter int MD_DEPTH = 2,
   parameter int CNT_W    = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [REG_AW-1:0] rs1d_i,
   input  logic [REG_AW-1:0] rs2d_i,
   input  logic [REG_AW-1:0] rdd_i,
   input  logic [REG_AW-1:0] rs1e_i,
   input  logic [REG_AW-1:0] rs2e_i,
   input  logic [REG_AW-1:0] rde_i,
   input  logic [REG_AW-1:0] rdm_i,
   input  logic [REG_AW-1:0] rdw_i,
   input  logic              reg_write_d_i,
   input  logic              reg_write_m_i,
   input  logic              reg_write_w_i,
   input  logic              result_src_e_i,
   input  logic              md_op_e_i,
   input  logic              pc_src_i,
   input  logic              mem_req_m_i,
   input  logic              dmem_ready_i,
   input  logic              md_done_i,
   input  logic [REG_AW-1:0] md_rd_i,
   output logic              stall_f_o,
   output logic              stall_d_o,
   output logic              stall_e_o,
   output logic              stall_m_o,
   output logic              flush_d_o,
   output logic              flush_e_o,
   output logic              flush_m_o,
   output logic              flush_w_o,
   output logic [1:0]        forwarding_a_o,
   output logic [1:0]        forwarding_b_o,
   output logic              md_start_o,
   output logic              md_busy_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);
   localparam int NREG  = 1 << REG_AW;
   localparam int MDC_W = $clog2(MD_DEPTH + 1);

   logic [NREG-1:0]  pend;
   logic [MDC_W-1:0] md_cnt;
   logic [CNT_W-1:0] stall_cnt;

   logic [NREG-1:0]  done_mask;
   logic [NREG-1:0]  start_mask;
   logic [NREG-1:0]  pend_vis;
   logic             mem_stall;
   logic             use_stall;
   logic             sb_raw;
   logic             sb_waw;
   logic             md_full;
   logic             md_start;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                          input logic              wm,
                                          input logic [REG_AW-1:0] rdm,
                                          input logic              ww,
                                          input logic [REG_AW-1:0] rdw);
      if (rs == '0)
         return 2'b00;
      if (wm && (rdm == rs))
         return 2'b10;
      if (ww && (rdw == rs))
         return 2'b01;
      return 2'b00;
   endfunction

   assign forwarding_a_o = fwd_sel(rs1e_i, reg_write_m_i, rdm_i, reg_write_w_i, rdw_i);
   assign forwarding_b_o = fwd_sel(rs2e_i, reg_write_m_i, rdm_i, reg_write_w_i, rdw_i);

   // A register completing this cycle is visible to D already (write-first register file).
   always_comb begin
      done_mask  = md_done_i ? (NREG'(1) << md_rd_i) : '0;
      start_mask = (md_start && (rde_i != '0)) ? (NREG'(1) << rde_i) : '0;
      pend_vis   = pend & ~done_mask;
   end

   always_comb begin
      mem_stall = mem_req_m_i & ~dmem_ready_i;
      use_stall = (result_src_e_i | md_op_e_i) & (rde_i != '0) &
                  ((rde_i == rs1d_i) | (rde_i == rs2d_i));
      sb_raw    = ((rs1d_i != '0) & pend_vis[rs1d_i]) |
                  ((rs2d_i != '0) & pend_vis[rs2d_i]);
      sb_waw    = reg_write_d_i & (rdd_i != '0) & pend_vis[rdd_i];
      md_full   = md_op_e_i & (md_cnt == MDC_W'(MD_DEPTH)) & ~md_done_i;
      md_start  = md_op_e_i & ~mem_stall & ~pc_src_i & ~md_full;
   end

   always_comb begin
      stall_f_o = 1'b0;
      stall_d_o = 1'b0;
      stall_e_o = 1'b0;
      stall_m_o = 1'b0;
      flush_d_o = 1'b0;
      flush_e_o = 1'b0;
      flush_m_o = 1'b0;
      flush_w_o = 1'b0;
      if (mem_stall) begin
         // The taken branch stays in E and is re-presented once memory is ready.
         stall_f_o = 1'b1;
         stall_d_o = 1'b1;
         stall_e_o = 1'b1;
         stall_m_o = 1'b1;
         flush_w_o = 1'b1;
      end else if (pc_src_i) begin
         flush_d_o = 1'b1;
         flush_e_o = 1'b1;
      end else if (md_full) begin
         stall_f_o = 1'b1;
         stall_d_o = 1'b1;
         stall_e_o = 1'b1;
         flush_m_o = 1'b1;
      end else if (use_stall || sb_raw || sb_waw) begin
         stall_f_o = 1'b1;
         stall_d_o = 1'b1;
         flush_e_o = 1'b1;
      end
   end

   assign md_start_o  = md_start;
   assign md_busy_o   = (md_cnt != '0);
   assign stall_cnt_o = stall_cnt;

   // Scoreboard: a new issue to the same register outranks the completion clearing it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend      <= '0;
         md_cnt    <= '0;
         stall_cnt <= '0;
      end else begin
         pend <= (pend & ~done_mask) | start_mask;
         if (md_start && !md_done_i)
            md_cnt <= md_cnt + MDC_W'(1);
         else if (!md_start && md_done_i && (md_cnt != '0))
            md_cnt <= md_cnt - MDC_W'(1);
         if (stall_f_o)
            stall_cnt <= sat_inc(stall_cnt);
      end
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage RV32 core, the successor to the single-cycle load-use/forwarding hazard logic. It keeps E-stage operand forwarding, load-use stalls and branch flushes. It adds a data-memory wait stall, a scoreboard tracking up to `MD_DEPTH` outstanding multi-cycle mul/div results (RAW/WAW/structural stalls), an `md_start_o` issue handshake, and a saturating stall-cycle counter. It sits beside the datapath and drives the stall/flush enables of the F/D/E/M/W pipeline registers.

## Interface
- `REG_AW`, 5: register address width; register file has 2^REG_AW entries, x0 hardwired zero.
- `MD_DEPTH`, 2: max outstanding mul/div ops (1..2^REG_AW-1).
- `CNT_W`, 32: stall counter width.
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `rs1d_i`, `rs2d_i`, `rdd_i` in REG_AW: D-stage sources/destination.
- `rs1e_i`, `rs2e_i`, `rde_i` in REG_AW: E-stage sources/destination.
- `rdm_i`, `rdw_i` in REG_AW: M/W-stage destinations.
- `reg_write_d_i`, `reg_write_m_i`, `reg_write_w_i` in 1: stage writes register file.
- `result_src_e_i` in 1: E-stage instruction is a load.
- `md_op_e_i` in 1: E-stage instruction is mul/div.
- `pc_src_i` in 1: branch/jump taken, resolved in E.
- `mem_req_m_i` in 1: M-stage load/store active.
- `dmem_ready_i` in 1: data memory accepts/completes this cycle.
- `md_done_i` in 1: mul/div unit writes result this cycle.
- `md_rd_i` in REG_AW: destination of completing mul/div.
- `stall_f_o`, `stall_d_o`, `stall_e_o`, `stall_m_o` out 1: hold stage register.
- `flush_d_o`, `flush_e_o`, `flush_m_o`, `flush_w_o` out 1: load bubble into stage register.
- `forwarding_a_o`, `forwarding_b_o` out 2: 10 = from M, 01 = from W, 00 = register file.
- `md_start_o` out 1: E-stage mul/div issued to unit this cycle.
- `md_busy_o` out 1: at least one mul/div outstanding.
- `stall_cnt_o` out CNT_W: cycles with `stall_f_o`=1, saturating.

## Operation
- State:
  - `pend[2^REG_AW]` is a per-register pending bitmap.
  - `md_cnt` is the outstanding count, 0..MD_DEPTH.
  - `stall_cnt` is the stall counter.
- Forwarding, per operand:
  - M match (`reg_write_m_i`, rs≠0, `rdm_i`==rs) gives 10.
  - Else W match gives 01.
  - Else 00.
  - Independent of stalls.
- Hazard terms:
  - `mem_stall` = `mem_req_m_i` & !`dmem_ready_i`.
  - `use_stall` = (`result_src_e_i` | `md_op_e_i`) & `rde_i`≠0 & (`rde_i`==`rs1d_i` | `rde_i`==`rs2d_i`).
  - `sb_raw` = rs1d/rs2d ≠0 with `pend` set, excluding a register cleared by `md_done_i` this cycle (write-first register file).
  - `sb_waw` = `reg_write_d_i` & `rdd_i`≠0 & `pend[rdd_i]` (same exclusion).
  - `md_full` = `md_op_e_i` & (`md_cnt`==MD_DEPTH) & !`md_done_i`.
- Priority, highest first; all outputs 0 unless set:
  1. `mem_stall`: `stall_f/d/e/m`=1, `flush_w`=1. The branch is held in E, so it re-presents next cycle.
  2. `pc_src_i`: `flush_d`=`flush_e`=1.
  3. `md_full`: `stall_f/d/e`=1, `flush_m`=1.
  4. `use_stall` | `sb_raw` | `sb_waw`: `stall_f/d`=1, `flush_e`=1.
- `md_start_o` = `md_op_e_i` & !`mem_stall` & !`pc_src_i` & !`md_full`.
- Scoreboard update at clock edge:
  - `md_start_o` with `rde_i`≠0 sets `pend[rde_i]`.
  - `md_done_i` clears `pend[md_rd_i]`.
  - Set wins on the same index.
  - `md_cnt` += `md_start_o` − `md_done_i`.
- `md_start_o` with `rde_i`==0 still counts in `md_cnt`; the unit still reports `md_done_i` for it.
- `md_done_i` with `md_cnt`==0 is illegal and is covered by a bench assertion; `md_cnt` must not underflow.
- `md_busy_o` = (`md_cnt`≠0).
- `stall_cnt` increments when `stall_f_o`=1 and holds at 2^CNT_W−1.

## Timing
- Forwarding, stall, flush and `md_start_o` are combinational, with zero-cycle latency.
- Scoreboard and counter are registered; they take effect the cycle after the edge.
- Reset (async, any time, including mid-mul/div):
  - `pend`=0, `md_cnt`=0, `stall_cnt`=0, so `md_busy_o`=0 and `stall_cnt_o`=0.
  - Combinational outputs follow their inputs; a pending op is dropped.
- A load-use bubble costs exactly 1 stall cycle.
- A mul/div RAW holds D until the cycle `md_done_i` clears the register; D proceeds in that same cycle.
- A `mem_stall` of N cycles holds F–M for N cycles; `stall_cnt` advances N.

## Test plan
- Forwarding: `rs1e`=5, `rdm`=5 with `reg_write_m`=1, `rdw`=5 with `reg_write_w`=1 -> `forwarding_a`=10. With `rdm`=0 -> 01. `rs1e`=0 -> 00.
- Load-use: `result_src_e`=1, `rde`=7, `rs2d`=7 -> `stall_f/d`=1, `flush_e`=1 for 1 cycle, `stall_cnt_o`=1. With `rde`=0 -> no stall.
- Mul/div RAW: MD to x9 issued (`md_start_o`=1, `md_busy_o`=1 next cycle); `rs1d`=9 -> stall every cycle until `md_done_i`/`md_rd`=9; stall drops that cycle; `md_busy_o`=0 after.
- Structural: MD_DEPTH=2, two ops pending, third `md_op_e` -> `stall_f/d/e`=1, `flush_m`=1, `md_start_o`=0. Same cycle as `md_done_i` -> issues.
- Memory wait plus branch: `mem_req_m`=1, `dmem_ready`=0 for 3 cycles with `pc_src`=1 -> `stall_f..m`=1, `flush_w`=1, `flush_d/e`=0. Then `flush_d/e`=1 on the ready cycle.
- Reset mid-op: 2 ops pending, `rst_ni` low asynchronously -> `md_busy_o`=0, `stall_cnt_o`=0 immediately. After release, no RAW stall on the old rd.
